// File: rtl/mac_issue_ctrl.sv
// mac_issue_ctrl: issues 8-lane operand groups to the mul-add block one at a time and accumulates its results
module mac_issue_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int LEN_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [1:0]       mode_i,
    input  logic             op_valid_i,
    output logic             op_ready_o,
    input  logic [16:0]      w_i [8],
    input  logic [16:0]      a_i [8],
    output logic [16:0]      weight_vals_o [8],
    output logic [16:0]      activations_o [8],
    output logic [1:0]       mode_o,
    output logic             enable_o,
    input  logic             occupied_i,
    input  logic             valid_out_i,
    input  logic [31:0]      results_i [4],
    output logic [31:0]      acc_o,
    output logic             done_o,
    output logic             busy_o,
    output logic             err_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, WAIT_OP, ISSUE, WAIT_RES, DONE} state_t;
    state_t state, state_nx;
    logic [TW-1:0] tcnt;
    logic [LEN_W-1:0] len_q, grp;
    logic [31:0] rsum;
    logic last, tmo;
    assign rsum = results_i[0] + results_i[1] + results_i[2] + results_i[3];
    assign last = (grp + LEN_W'(1)) == len_q;
    assign tmo = tcnt == TW'(TIMEOUT - 1);
    assign op_ready_o = state == WAIT_OP;
    assign enable_o = (state == ISSUE) && !occupied_i;
    assign done_o = state == DONE;
    assign busy_o = state != IDLE;
    // state register
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) state <= IDLE;
        else state <= state_nx;
    // next-state: a valid result on the final timeout cycle beats the timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start_i) state_nx = (len_i == '0) ? DONE : WAIT_OP;
            WAIT_OP:  if (op_valid_i) state_nx = ISSUE;
            ISSUE:    if (!occupied_i) state_nx = WAIT_RES;
            WAIT_RES: state_nx = valid_out_i ? (last ? DONE : WAIT_OP) : (tmo ? IDLE : WAIT_RES);
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    // operand capture, accumulation, group and timeout counting
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            weight_vals_o <= '{default: '0};
            activations_o <= '{default: '0};
            mode_o <= '0;
            acc_o <= '0;
            err_o <= 1'b0;
            len_q <= '0;
            grp <= '0;
            tcnt <= '0;
        end else begin
            if (state == IDLE && start_i) begin
                len_q <= len_i;
                mode_o <= mode_i;
                acc_o <= '0;
                grp <= '0;
                err_o <= 1'b0;
            end
            if (op_ready_o && op_valid_i) begin
                weight_vals_o <= w_i;
                activations_o <= a_i;
            end
            if (enable_o) tcnt <= '0;
            if (state == WAIT_RES) begin
                if (valid_out_i) begin
                    acc_o <= acc_o + rsum;
                    grp <= grp + LEN_W'(1);
                end else if (tmo) err_o <= 1'b1;
                else tcnt <= tcnt + TW'(1);
            end
        end
endmodule

// File: tb/tb_mac_issue_ctrl.sv
// tb_mac_issue_ctrl: randomized self-checking bench for mac_issue_ctrl with a sum-of-results reference model
module tb_mac_issue_ctrl;
    localparam int TO = 16;
    logic clk_i = 0, rst_ni = 0, start_i = 0, op_valid_i = 0, occupied_i = 0, valid_out_i = 0;
    logic [7:0] len_i = 0;
    logic [1:0] mode_i = 0;
    logic [16:0] w_i [8], a_i [8], weight_vals_o [8], activations_o [8];
    logic [31:0] results_i [4];
    logic op_ready_o, enable_o, done_o, busy_o, err_o;
    logic [1:0] mode_o;
    logic [31:0] acc_o;
    int tests = 0, fails = 0, en_cnt = 0, done_cnt = 0;

    mac_issue_ctrl #(.TIMEOUT(TO), .LEN_W(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .len_i(len_i), .mode_i(mode_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .w_i(w_i), .a_i(a_i),
        .weight_vals_o(weight_vals_o), .activations_o(activations_o), .mode_o(mode_o),
        .enable_o(enable_o), .occupied_i(occupied_i), .valid_out_i(valid_out_i),
        .results_i(results_i), .acc_o(acc_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(negedge clk_i) begin
        en_cnt += int'(enable_o);
        done_cnt += int'(done_o);
    end
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start(input logic [7:0] len);
        start_i = 1;
        len_i = len;
        mode_i = 2'($urandom);
        tick();
        start_i = 0;
        len_i = 8'($urandom);
    endtask

    function automatic bit outs_zero();
        bit z = 1;
        for (int i = 0; i < 8; i++) if (weight_vals_o[i] !== '0 || activations_o[i] !== '0) z = 0;
        if ({mode_o, enable_o, op_ready_o, acc_o, done_o, busy_o, err_o} !== '0) z = 0;
        return z;
    endfunction

    function automatic logic [31:0] rsum(input logic [31:0] r [4]);
        return r[0] + r[1] + r[2] + r[3];
    endfunction

    // Drives one operand group from WAIT_OP through its result; ok drops on any protocol anomaly
    task automatic drive_group(input int occ, input int lat, input logic [31:0] r [4], output bit ok);
        logic [16:0] w [8], a [8];
        ok = 1;
        for (int i = 0; i < 8; i++) begin w[i] = 17'($urandom); a[i] = 17'($urandom); end
        for (int k = 0; k < 20 && op_ready_o !== 1'b1; k++) tick();
        if (op_ready_o !== 1'b1) ok = 0;
        op_valid_i = 1; w_i = w; a_i = a; occupied_i = occ > 0;
        tick();
        op_valid_i = 0;
        for (int i = 0; i < 8; i++) begin w_i[i] = 17'($urandom); a_i[i] = 17'($urandom); end
        for (int k = 0; k < occ; k++) begin
            #1 if (enable_o !== 1'b0) ok = 0;
            tick();
        end
        occupied_i = 0;
        #1 if (enable_o !== 1'b1) ok = 0;
        tick();
        for (int k = 0; k < lat; k++) begin
            occupied_i = 1'($urandom);
            op_valid_i = 1'($urandom);
            #1 if (weight_vals_o != w || activations_o != a || enable_o !== 1'b0) ok = 0;
            tick();
        end
        op_valid_i = 0; occupied_i = 0;
        valid_out_i = 1; results_i = r;
        #1 if (weight_vals_o != w || activations_o != a) ok = 0;
        tick();
        valid_out_i = 0;
        for (int i = 0; i < 4; i++) results_i[i] = $urandom;
    endtask

    task automatic test_reset();
        #1 tests++;
        if (!outs_zero()) begin fails++; $display("FAIL reset_outputs acc=%h busy=%b required all zero", acc_o, busy_o); end
        rst_ni = 1;
        tick(); tick();
        tests++;
        if (!outs_zero()) begin fails++; $display("FAIL idle_outputs acc=%h busy=%b required all zero", acc_o, busy_o); end
    endtask

    task automatic test_len_zero();
        int e0 = en_cnt;
        start(0);
        tests++;
        if (done_o !== 1'b1 || acc_o !== 32'd0) begin fails++; $display("FAIL len0_done done=%b acc=%h required 1/0", done_o, acc_o); end
        tick();
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || en_cnt != e0) begin
            fails++; $display("FAIL len0_after done=%b busy=%b enables=%0d required 0/0/0", done_o, busy_o, en_cnt - e0);
        end
    endtask

    task automatic test_basic();
        int e0 = en_cnt, d0 = done_cnt;
        logic [1:0] m;
        bit ok;
        start(3);
        m = dut.mode_o;
        tests++;
        if (busy_o !== 1'b1 || op_ready_o !== 1'b1) begin fails++; $display("FAIL start_ready busy=%b ready=%b required 1/1", busy_o, op_ready_o); end
        for (int g = 0; g < 3; g++) begin
            drive_group(0, 3, '{1, 2, 3, 4}, ok);
            tests++;
            if (!ok) begin fails++; $display("FAIL basic_group%0d ok=%b required 1", g, ok); end
            if (g < 2) begin
                tests++;
                if (op_ready_o !== 1'b1 || done_o !== 1'b0) begin fails++; $display("FAIL basic_next%0d ready=%b done=%b required 1/0", g, op_ready_o, done_o); end
            end
        end
        tests++;
        if (done_o !== 1'b1 || acc_o !== 32'd30) begin fails++; $display("FAIL basic_done done=%b acc=%0d required 1/30", done_o, acc_o); end
        tick();
        tests++;
        if (en_cnt - e0 != 3 || done_cnt - d0 != 1 || acc_o !== 32'd30 || mode_o !== m) begin
            fails++; $display("FAIL basic_counts enables=%0d dones=%0d acc=%0d required 3/1/30", en_cnt - e0, done_cnt - d0, acc_o);
        end
    endtask

    task automatic test_occupied();
        int e0 = en_cnt;
        logic [31:0] r [4] = '{9, 8, 7, 6};
        bit ok;
        start(1);
        drive_group(5, 4, r, ok);
        tests++;
        if (!ok || en_cnt - e0 != 1) begin fails++; $display("FAIL occupied ok=%b enables=%0d required 1/1", ok, en_cnt - e0); end
        tests++;
        if (done_o !== 1'b1 || acc_o !== 32'd30) begin fails++; $display("FAIL occupied_acc done=%b acc=%0d required 1/30", done_o, acc_o); end
        tick();
    endtask

    task automatic test_wrap();
        bit ok1, ok2;
        start(2);
        drive_group(0, 2, '{32'h7FFFFFFF, 1, 0, 0}, ok1);
        drive_group(1, 2, '{32'hFFFFFFFF, 0, 0, 0}, ok2);
        tests++;
        if (!ok1 || !ok2 || done_o !== 1'b1 || acc_o !== 32'h7FFFFFFF) begin
            fails++; $display("FAIL wrap acc=%h done=%b required 7fffffff/1", acc_o, done_o);
        end
        tick();
    endtask

    task automatic test_random();
        for (int d = 0; d < 8; d++) begin
            int len = $urandom_range(1, 5);
            int e0 = en_cnt;
            logic [31:0] exp = 0;
            logic [31:0] r [4];
            bit ok, all_ok = 1;
            start(8'(len));
            for (int g = 0; g < len; g++) begin
                for (int i = 0; i < 4; i++) r[i] = $urandom;
                exp += rsum(r);
                drive_group($urandom_range(0, 3), $urandom_range(1, 6), r, ok);
                all_ok &= ok;
            end
            tests++;
            if (!all_ok || done_o !== 1'b1 || acc_o !== exp || en_cnt - e0 != len) begin
                fails++; $display("FAIL random%0d acc=%h done=%b enables=%0d required %h/1/%0d", d, acc_o, done_o, en_cnt - e0, exp, len);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int d0 = done_cnt;
        logic [31:0] exp;
        bit ok, quiet = 1;
        start(2);
        drive_group(0, 2, '{5, 6, 7, 8}, ok);
        exp = 26;
        op_valid_i = 1;
        tick();
        op_valid_i = 0;
        tests++;
        if (!ok || enable_o !== 1'b1) begin fails++; $display("FAIL timeout_issue ok=%b enable=%b required 1/1", ok, enable_o); end
        tick();
        for (int k = 1; k <= TO; k++) begin
            if (err_o !== 1'b0 || busy_o !== 1'b1) quiet = 0;
            tick();
        end
        tests++;
        if (!quiet) begin fails++; $display("FAIL timeout_early err/busy changed before %0d cycles, required err=0 busy=1", TO); end
        tests++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || acc_o !== exp || done_cnt != d0) begin
            fails++; $display("FAIL timeout err=%b busy=%b acc=%0d dones=%0d required 1/0/%0d/0", err_o, busy_o, acc_o, done_cnt - d0, exp);
        end
        tick();
        tests++;
        if (err_o !== 1'b1) begin fails++; $display("FAIL timeout_sticky err=%b required 1", err_o); end
        start(0);
        tests++;
        if (err_o !== 1'b0 || done_o !== 1'b1) begin fails++; $display("FAIL timeout_clear err=%b done=%b required 0/1", err_o, done_o); end
        tick();
    endtask

    task automatic test_timeout_edge();
        start(1);
        op_valid_i = 1;
        tick();
        op_valid_i = 0;
        tick();
        for (int k = 1; k < TO; k++) tick();
        valid_out_i = 1;
        results_i = '{10, 20, 30, 40};
        tick();
        valid_out_i = 0;
        tests++;
        if (err_o !== 1'b0 || done_o !== 1'b1 || acc_o !== 32'd100) begin
            fails++; $display("FAIL timeout_edge err=%b done=%b acc=%0d required 0/1/100", err_o, done_o, acc_o);
        end
        tick();
    endtask

    task automatic test_ignored();
        logic [16:0] w0;
        logic [31:0] r1 [4] = '{3, 3, 3, 3}, r2 [4] = '{1, 1, 1, 1};
        bit ok1, ok2;
        w0 = weight_vals_o[0];
        op_valid_i = 1;
        w_i[0] = ~w0;
        tick();
        op_valid_i = 0;
        tests++;
        if (weight_vals_o[0] !== w0 || busy_o !== 1'b0) begin fails++; $display("FAIL idle_opvalid w0=%h busy=%b required %h/0", weight_vals_o[0], busy_o, w0); end
        start(2);
        for (int k = 0; k < 3; k++) begin
            start_i = 1; len_i = 0;
            valid_out_i = 1; results_i = '{100, 100, 100, 100};
            tick();
        end
        start_i = 0; valid_out_i = 0;
        tests++;
        if (acc_o !== 32'd0 || op_ready_o !== 1'b1 || done_o !== 1'b0) begin
            fails++; $display("FAIL stray acc=%0d ready=%b done=%b required 0/1/0", acc_o, op_ready_o, done_o);
        end
        drive_group(0, 2, r1, ok1);
        tests++;
        if (!ok1 || done_o !== 1'b0 || acc_o !== 32'd12) begin fails++; $display("FAIL stray_count acc=%0d done=%b required 12/0", acc_o, done_o); end
        drive_group(0, 2, r2, ok2);
        tests++;
        if (!ok2 || done_o !== 1'b1 || acc_o !== 32'd16) begin fails++; $display("FAIL stray_final acc=%0d done=%b required 16/1", acc_o, done_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        start(3);
        op_valid_i = 1;
        w_i[0] = 17'h1ABCD;
        tick();
        op_valid_i = 0;
        tick();
        occupied_i = 1;
        tick();
        rst_ni = 0;
        #1 tests++;
        if (!outs_zero()) begin fails++; $display("FAIL reset_mid acc=%h busy=%b w0=%h required all zero", acc_o, busy_o, weight_vals_o[0]); end
        occupied_i = 0;
        tick();
        rst_ni = 1;
        tick();
        tests++;
        if (!outs_zero()) begin fails++; $display("FAIL reset_mid_after acc=%h busy=%b required all zero", acc_o, busy_o); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin w_i[i] = 0; a_i[i] = 0; end
        for (int i = 0; i < 4; i++) results_i[i] = 0;
        test_reset();
        test_len_zero();
        test_basic();
        test_occupied();
        test_wrap();
        test_random();
        test_timeout();
        test_timeout_edge();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
